// File: rtl/fifo_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// fifo_ctrl_pkg
//   Shared constants and types for the multi-requester FIFO write controller.
//   - FIFO_DSIZE / FIFO_ASIZE / FIFO_NREQ / FIFO_AF_LEVEL : default geometry
//   - ptr_t      : read/write pointer type (one wrap bit above the address)
//   - idx_width  : width of a requester index (at least 1 bit)
// ---------------------------------------------------------------------------
package fifo_ctrl_pkg;

  localparam int FIFO_DSIZE    = 8;
  localparam int FIFO_ASIZE    = 4;
  localparam int FIFO_NREQ     = 4;
  localparam int FIFO_AF_LEVEL = 12;

  // The extra MSB tells a full FIFO apart from an empty one when the
  // address bits of the two pointers match.
  typedef logic [FIFO_ASIZE:0] ptr_t;

  // Index width for n requesters; a single requester still gets one bit
  // so that no zero-width vectors appear.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : fifo_ctrl_pkg

// File: rtl/fifo_wr_arb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//   Purely combinational round-robin search. Starting at index prio and
//   wrapping around, the first asserted req bit wins.
//   Ports:
//     req      in   NREQ  request vector
//     prio     in   IW    index where the search starts
//     gnt      out  NREQ  one-hot grant (all zero when no request)
//     gnt_idx  out  IW    index of the granted requester
//     gnt_vld  out  1     some request was found
// ---------------------------------------------------------------------------
module rr_arbiter
  import fifo_ctrl_pkg::*;
#(
  parameter int NREQ = FIFO_NREQ,
  parameter int IW   = idx_width(FIFO_NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   prio,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   gnt_idx,
  output logic            gnt_vld
);

  logic [IW-1:0] scan_idx;

  always_comb begin
    gnt      = '0;
    gnt_idx  = '0;
    gnt_vld  = 1'b0;
    scan_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      // Visit prio, prio+1, ... modulo NREQ; the first hit is kept.
      scan_idx = IW'((int'(prio) + k) % NREQ);
      if (!gnt_vld && req[scan_idx]) begin
        gnt_vld       = 1'b1;
        gnt_idx       = scan_idx;
        gnt[scan_idx] = 1'b1;
      end
    end
  end

endmodule : rr_arbiter

// File: rtl/fifo_wr_arb.sv
// ---------------------------------------------------------------------------
// fifo_wr_arb
//   Write-side controller for a 2**ASIZE x DSIZE FIFO memory shared by NREQ
//   requesters. A round-robin arbiter picks one requester per cycle, the
//   winner's word is written at the write pointer, and the consumer pops
//   from the read pointer. The memory itself sits outside this block.
//
//   Ports:
//     wclk       in   1            clock, rising edge
//     wrst       in   1            synchronous active-high reset
//     req_valid  in   NREQ         per-requester write request
//     req_data   in   NREQ*DSIZE   requester i data at [i*DSIZE +: DSIZE]
//     req_ready  out  NREQ         one-hot accept strobe
//     rd_en      in   1            consumer pop request
//     wclken     out  1            memory write enable
//     waddr      out  ASIZE        memory write address
//     wdata      out  DSIZE        memory write data
//     raddr      out  ASIZE        memory read address (head entry)
//     wfull      out  1            FIFO full / memory write inhibit
//     rempty     out  1            FIFO empty
//     count      out  ASIZE+1      occupancy 0..2**ASIZE
//     almost_full  out 1           (FIFO_ALMOST_FLAGS_EN) count >= AF_LEVEL
//     almost_empty out 1           (FIFO_ALMOST_FLAGS_EN) count <= 1
//
//   Build option: define FIFO_ALMOST_FLAGS_EN to add almost_full and
//   almost_empty; without it those ports do not exist.
//
//   Handshake: a requester presents req_data with req_valid and holds both
//   until it sees req_ready. req_ready is combinational from req_valid, the
//   round-robin priority and wfull; the word is taken on the rising edge
//   where req_valid & req_ready are both 1. At most one ready bit is set.
// ---------------------------------------------------------------------------
module fifo_wr_arb
  import fifo_ctrl_pkg::*;
#(
  parameter int DSIZE    = FIFO_DSIZE,
  parameter int ASIZE    = FIFO_ASIZE,
  parameter int NREQ     = FIFO_NREQ,
  parameter int AF_LEVEL = FIFO_AF_LEVEL
) (
  input  logic                  wclk,
  input  logic                  wrst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*DSIZE-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  input  logic                  rd_en,
  output logic                  wclken,
  output logic [ASIZE-1:0]      waddr,
  output logic [DSIZE-1:0]      wdata,
  output logic [ASIZE-1:0]      raddr,
  output logic                  wfull,
  output logic                  rempty,
  output logic [ASIZE:0]        count
`ifdef FIFO_ALMOST_FLAGS_EN
  ,
  output logic                  almost_full,
  output logic                  almost_empty
`endif
);

  localparam int IW = idx_width(NREQ);

  logic [ASIZE:0]   wptr;
  logic [ASIZE:0]   rptr;
  logic [IW-1:0]    prio;

  logic [NREQ-1:0]  cand_gnt;
  logic [IW-1:0]    cand_idx;
  logic             cand_vld;

  logic             grant;
  logic             pop;

  // ---------------------------------------------------------------------
  // Round-robin candidate selection
  // ---------------------------------------------------------------------
  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_arbiter (
    .req     (req_valid),
    .prio    (prio),
    .gnt     (cand_gnt),
    .gnt_idx (cand_idx),
    .gnt_vld (cand_vld)
  );

  // ---------------------------------------------------------------------
  // Status decode, straight from the registered pointers
  // ---------------------------------------------------------------------
  assign wfull  = (wptr[ASIZE] != rptr[ASIZE]) &&
                  (wptr[ASIZE-1:0] == rptr[ASIZE-1:0]);
  assign rempty = (wptr == rptr);
  assign count  = wptr - rptr;
  assign waddr  = wptr[ASIZE-1:0];
  assign raddr  = rptr[ASIZE-1:0];

  // A pop while full frees a slot only after the edge, so a full FIFO
  // refuses writes this cycle regardless of rd_en. Reset also blocks
  // writes so the memory is never touched while wrst is high.
  assign grant     = cand_vld && !wfull && !wrst;
  assign pop       = rd_en && !rempty && !wrst;
  assign wclken    = grant;
  assign req_ready = grant ? cand_gnt : '0;

  // Winner's data; only meaningful while wclken is high.
  always_comb begin
    wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (cand_idx == IW'(i)) begin
        wdata = req_data[i*DSIZE +: DSIZE];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Pointer and priority registers
  // ---------------------------------------------------------------------
  always_ff @(posedge wclk) begin
    if (wrst) begin
      wptr <= '0;
      rptr <= '0;
      prio <= '0;
    end else begin
      if (grant) begin
        wptr <= wptr + (ASIZE+1)'(1);
        // The requester after the winner gets first look next time.
        if (cand_idx == IW'(NREQ-1)) begin
          prio <= '0;
        end else begin
          prio <= cand_idx + IW'(1);
        end
      end
      if (pop) begin
        rptr <= rptr + (ASIZE+1)'(1);
      end
    end
  end

`ifdef FIFO_ALMOST_FLAGS_EN
  // ---------------------------------------------------------------------
  // Almost flags, held low through reset
  // ---------------------------------------------------------------------
  assign almost_full  = !wrst && (count >= (ASIZE+1)'(AF_LEVEL));
  assign almost_empty = !wrst && (count <= (ASIZE+1)'(1));
`endif

endmodule : fifo_wr_arb

// File: tb/tb_fifo_wr_arb.sv
// ---------------------------------------------------------------------------
// tb_fifo_wr_arb
//   Directed bench for fifo_wr_arb with a behavioural 16x8 memory attached
//   to the write/read ports. Each scenario task drives stimulus and checks
//   outputs 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_fifo_wr_arb;
  import fifo_ctrl_pkg::*;

  logic        wclk;
  logic        wrst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        rd_en;
  logic        wclken;
  logic [3:0]  waddr;
  logic [7:0]  wdata;
  logic [3:0]  raddr;
  logic        wfull;
  logic        rempty;
  logic [4:0]  count;
`ifdef FIFO_ALMOST_FLAGS_EN
  logic        almost_full;
  logic        almost_empty;
`endif

  int n_vec = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];

  fifo_wr_arb dut (
    .wclk      (wclk),
    .wrst      (wrst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rd_en     (rd_en),
    .wclken    (wclken),
    .waddr     (waddr),
    .wdata     (wdata),
    .raddr     (raddr),
    .wfull     (wfull),
    .rempty    (rempty),
    .count     (count)
`ifdef FIFO_ALMOST_FLAGS_EN
    ,
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
`endif
  );

  // Clock / reset block
  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  // Behavioural FIFO memory, write inhibited by wfull
  logic [7:0] mem [16];
  logic [7:0] rdata;
  always @(posedge wclk) begin
    if (wclken && !wfull) mem[waddr] <= wdata;
  end
  assign rdata = mem[raddr];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic step();
    @(posedge wclk);
    #1;
  endtask

  task automatic do_reset();
    wrst      = 1'b1;
    req_valid = '0;
    req_data  = '0;
    rd_en     = 1'b0;
    step();
    step();
    wrst = 1'b0;
    exp_q.delete();
    #1;
  endtask

  // ---------------------------------------------------------------------
  task automatic test_reset();
    wrst = 1'b1; req_valid = 4'b1111; req_data = 32'hDDCC_BBAA; rd_en = 1'b1;
    step();
    n_vec++; if (req_ready !== 4'b0000 || wclken !== 1'b0) begin
      n_bad++; $display("FAIL reset_no_write: ready=%b wclken=%b, want 0000/0", req_ready, wclken);
    end
    n_vec++; if (count !== 5'd0 || rempty !== 1'b1 || wfull !== 1'b0) begin
      n_bad++; $display("FAIL reset_state: count=%0d rempty=%b wfull=%b, want 0/1/0", count, rempty, wfull);
    end
    wrst = 1'b0; req_valid = '0; rd_en = 1'b0;
    #1;
  endtask

  // ---------------------------------------------------------------------
  task automatic test_fill();
    do_reset();
    req_data  = 32'hA3A2_A1A0;
    req_valid = 4'b1111;
    #1;
    for (int k = 0; k < 16; k++) begin
      n_vec++; if (req_ready !== 4'(1 << (k % 4))) begin
        n_bad++; $display("FAIL fill_grant k=%0d: ready=%b want %b", k, req_ready, 4'(1 << (k % 4)));
      end
      n_vec++; if (wclken !== 1'b1 || waddr !== 4'(k) || wdata !== 8'hA0 + 8'(k % 4)) begin
        n_bad++; $display("FAIL fill_write k=%0d: wclken=%b waddr=%0d wdata=%h want 1/%0d/%h",
                          k, wclken, waddr, wdata, k, 8'hA0 + 8'(k % 4));
      end
      n_vec++; if (count !== 5'(k)) begin
        n_bad++; $display("FAIL fill_count k=%0d: count=%0d want %0d", k, count, k);
      end
      exp_q.push_back(8'hA0 + 8'(k % 4));
      step();
    end
    n_vec++; if (wfull !== 1'b1 || count !== 5'd16) begin
      n_bad++; $display("FAIL fill_full: wfull=%b count=%0d want 1/16", wfull, count);
    end
    n_vec++; if (wclken !== 1'b0 || req_ready !== 4'b0000) begin
      n_bad++; $display("FAIL full_no_write: wclken=%b ready=%b want 0/0000", wclken, req_ready);
    end
    step();
    n_vec++; if (count !== 5'd16 || wclken !== 1'b0) begin
      n_bad++; $display("FAIL full_hold: count=%0d wclken=%b want 16/0", count, wclken);
    end
  endtask

  // Continues from the full state left by test_fill.
  task automatic test_full_pop();
    rd_en = 1'b1; req_valid = 4'b0001;
    #1;
    n_vec++; if (req_ready !== 4'b0000 || wclken !== 1'b0) begin
      n_bad++; $display("FAIL fullpop_block: ready=%b wclken=%b want 0000/0", req_ready, wclken);
    end
    n_vec++; if (rdata !== exp_q[0]) begin
      n_bad++; $display("FAIL fullpop_head0: rdata=%h want %h", rdata, exp_q[0]);
    end
    step();
    void'(exp_q.pop_front());
    n_vec++; if (count !== 5'd15) begin
      n_bad++; $display("FAIL fullpop_count1: count=%0d want 15", count);
    end
    n_vec++; if (req_ready !== 4'b0001 || wclken !== 1'b1 || waddr !== 4'd0) begin
      n_bad++; $display("FAIL fullpop_push: ready=%b wclken=%b waddr=%0d want 0001/1/0", req_ready, wclken, waddr);
    end
    n_vec++; if (rdata !== exp_q[0]) begin
      n_bad++; $display("FAIL fullpop_head1: rdata=%h want %h", rdata, exp_q[0]);
    end
    exp_q.push_back(8'hA0);
    step();
    void'(exp_q.pop_front());
    n_vec++; if (count !== 5'd15 || wfull !== 1'b0) begin
      n_bad++; $display("FAIL fullpop_count2: count=%0d wfull=%b want 15/0", count, wfull);
    end
    rd_en = 1'b0; req_valid = '0;
    #1;
  endtask

  // ---------------------------------------------------------------------
  task automatic test_empty_read();
    do_reset();
    rd_en = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      n_vec++; if (raddr !== 4'd0 || rempty !== 1'b1 || count !== 5'd0 || dut.rptr !== ptr_t'(0)) begin
        n_bad++; $display("FAIL empty_read c=%0d: raddr=%0d rempty=%b count=%0d rptr=%0d want 0/1/0/0",
                          c, raddr, rempty, count, dut.rptr);
      end
    end
    rd_en = 1'b0;
    #1;
  endtask

  // ---------------------------------------------------------------------
  task automatic test_order();
    do_reset();
    req_data = 32'h00A5_0000; req_valid = 4'b0100;
    #1;
    n_vec++; if (req_ready !== 4'b0100 || waddr !== 4'd0 || wdata !== 8'hA5) begin
      n_bad++; $display("FAIL order_w0: ready=%b waddr=%0d wdata=%h want 0100/0/a5", req_ready, waddr, wdata);
    end
    step();
    req_data = 32'h0000_003C; req_valid = 4'b0001;
    #1;
    n_vec++; if (req_ready !== 4'b0001 || waddr !== 4'd1 || wdata !== 8'h3C) begin
      n_bad++; $display("FAIL order_w1: ready=%b waddr=%0d wdata=%h want 0001/1/3c", req_ready, waddr, wdata);
    end
    step();
    req_valid = '0;
    #1;
    n_vec++; if (rdata !== 8'hA5 || count !== 5'd2) begin
      n_bad++; $display("FAIL order_r0: rdata=%h count=%0d want a5/2", rdata, count);
    end
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    #1;
    n_vec++; if (rdata !== 8'h3C || raddr !== 4'd1 || count !== 5'd1) begin
      n_bad++; $display("FAIL order_r1: rdata=%h raddr=%0d count=%0d want 3c/1/1", rdata, raddr, count);
    end
  endtask

  // ---------------------------------------------------------------------
  task automatic test_wrap();
    do_reset();
    req_data = 32'h0000_0055; req_valid = 4'b0001; rd_en = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step();
      n_vec++; if (count !== 5'd1) begin
        n_bad++; $display("FAIL wrap_count c=%0d: count=%0d want 1", c, count);
      end
    end
    req_valid = '0;
    step();
    rd_en = 1'b0;
    #1;
    n_vec++; if (count !== 5'd0 || rempty !== 1'b1 || waddr !== 4'd4 || raddr !== 4'd4) begin
      n_bad++; $display("FAIL wrap_end: count=%0d rempty=%b waddr=%0d raddr=%0d want 0/1/4/4",
                        count, rempty, waddr, raddr);
    end
    n_vec++; if (dut.wptr !== ptr_t'(20) || dut.rptr !== ptr_t'(20)) begin
      n_bad++; $display("FAIL wrap_msb: wptr=%0d rptr=%0d want 20/20", dut.wptr, dut.rptr);
    end
  endtask

  // ---------------------------------------------------------------------
  task automatic test_mid_reset();
    do_reset();
    req_data = 32'h1413_1211; req_valid = 4'b1111;
    for (int c = 0; c < 7; c++) step();
    n_vec++; if (count !== 5'd7) begin
      n_bad++; $display("FAIL midrst_pre: count=%0d want 7", count);
    end
    wrst = 1'b1;
    #1;
    n_vec++; if (req_ready !== 4'b0000 || wclken !== 1'b0) begin
      n_bad++; $display("FAIL midrst_block: ready=%b wclken=%b want 0000/0", req_ready, wclken);
    end
    step();
    wrst = 1'b0;
    #1;
    n_vec++; if (count !== 5'd0 || rempty !== 1'b1 || wfull !== 1'b0) begin
      n_bad++; $display("FAIL midrst_state: count=%0d rempty=%b wfull=%b want 0/1/0", count, rempty, wfull);
    end
    n_vec++; if (req_ready !== 4'b0001) begin
      n_bad++; $display("FAIL midrst_prio: ready=%b want 0001", req_ready);
    end
    req_valid = '0;
    #1;
  endtask

`ifdef FIFO_ALMOST_FLAGS_EN
  // ---------------------------------------------------------------------
  task automatic test_almost();
    do_reset();
    req_data = 32'h0000_0077; req_valid = 4'b0001;
    #1;
    for (int k = 0; k <= 12; k++) begin
      n_vec++; if (almost_full !== (k >= 12) || almost_empty !== (k <= 1)) begin
        n_bad++; $display("FAIL almost k=%0d: af=%b ae=%b want %b/%b", k, almost_full, almost_empty,
                          (k >= 12), (k <= 1));
      end
      if (k < 12) step();
    end
    req_valid = '0;
    wrst = 1'b1;
    #1;
    n_vec++; if (almost_full !== 1'b0 || almost_empty !== 1'b0) begin
      n_bad++; $display("FAIL almost_rst: af=%b ae=%b want 0/0", almost_full, almost_empty);
    end
    step();
    wrst = 1'b0;
    #1;
  endtask
`endif

  // ---------------------------------------------------------------------
  initial begin
    wrst = 1'b1; req_valid = '0; req_data = '0; rd_en = 1'b0;
    step();
    test_reset();
    test_fill();
    test_full_pop();
    test_empty_read();
    test_order();
    test_wrap();
    test_mid_reset();
`ifdef FIFO_ALMOST_FLAGS_EN
    test_almost();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_fifo_wr_arb
